// File: rtl/ctrl_flush_redirect_if.sv
// Bundle between the EX hazard detector / fetch unit (master) and the flush-redirect controller (slave).
// Handshake: redirect_pc is held stable while redirect_valid=1; a transfer happens on a cycle where redirect_valid & if_ready.
interface ctrl_flush_redirect_if #(
   parameter int XLEN = 32
);
   logic            control_hazard;
   logic [XLEN-1:0] ex_target;
   logic            load_use_stall;
   logic            if_ready;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            flush_ifid;
   logic            flush_idex;
   logic            pc_stall;
   logic            busy;
   logic [31:0]     perf_flush_cnt;
   logic [31:0]     perf_penalty_cnt;
   logic [1:0]      state_dbg;

   modport master (
      output control_hazard, ex_target, load_use_stall, if_ready,
      input  redirect_valid, redirect_pc, flush_ifid, flush_idex, pc_stall, busy,
             perf_flush_cnt, perf_penalty_cnt, state_dbg
   );

   modport slave (
      input  control_hazard, ex_target, load_use_stall, if_ready,
      output redirect_valid, redirect_pc, flush_ifid, flush_idex, pc_stall, busy,
             perf_flush_cnt, perf_penalty_cnt, state_dbg
   );
endinterface

// File: rtl/ctrl_flush_redirect.sv
// Control-hazard consumer: latches the EX target, redirects fetch, squashes wrong-path IF/ID and ID/EX.
// Optional performance counters are enabled with the FLUSH_PERF_EN macro.
module ctrl_flush_redirect #(
   parameter int XLEN         = 32,
   parameter int DRAIN_CYCLES = 1
) (
   input logic                 clk,
   input logic                 rst_n,
   ctrl_flush_redirect_if.slave bus_if
);
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      DRAIN    = 2'd2
   } state_e;

   localparam logic [2:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 3'(DRAIN_CYCLES - 1) : 3'd0;

   state_e          state_q;
   logic [XLEN-1:0] redirect_pc_q;
   logic [2:0]      drain_cnt_q;
   logic            redirect_valid_q;
   logic            flush_ifid_q;
   logic            flush_idex_q;

   logic idle;
   logic take_hz;
   logic flush_ifid;
   logic flush_idex;

   // Reset gates the combinational IDLE terms so every output reads 0 while rst_n is low.
   assign idle       = (state_q == IDLE);
   assign take_hz    = idle & bus_if.control_hazard & rst_n;
   assign flush_ifid = flush_ifid_q | take_hz;
   assign flush_idex = flush_idex_q | take_hz;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         redirect_pc_q    <= '0;
         drain_cnt_q      <= 3'd0;
         redirect_valid_q <= 1'b0;
         flush_ifid_q     <= 1'b0;
         flush_idex_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus_if.control_hazard) begin
                  state_q          <= REDIRECT;
                  redirect_pc_q    <= bus_if.ex_target;
                  redirect_valid_q <= 1'b1;
                  flush_ifid_q     <= 1'b1;
                  flush_idex_q     <= 1'b1;
               end
            end
            REDIRECT: begin
               if (bus_if.if_ready) begin
                  redirect_valid_q <= 1'b0;
                  flush_idex_q     <= 1'b0;
                  if (DRAIN_CYCLES == 0) begin
                     state_q      <= IDLE;
                     flush_ifid_q <= 1'b0;
                  end else begin
                     state_q      <= DRAIN;
                     drain_cnt_q  <= DRAIN_LOAD;
                     flush_ifid_q <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               // Covers the fetch already in flight in the synchronous imem.
               if (drain_cnt_q == 3'd0) begin
                  state_q      <= IDLE;
                  flush_ifid_q <= 1'b0;
               end else begin
                  drain_cnt_q <= drain_cnt_q - 3'd1;
               end
            end
            default: begin
               state_q          <= IDLE;
               redirect_valid_q <= 1'b0;
               flush_ifid_q     <= 1'b0;
               flush_idex_q     <= 1'b0;
            end
         endcase
      end
   end

   assign bus_if.redirect_valid = redirect_valid_q;
   assign bus_if.redirect_pc    = redirect_pc_q;
   assign bus_if.flush_ifid     = flush_ifid;
   assign bus_if.flush_idex     = flush_idex;
   assign bus_if.pc_stall       = idle & ~bus_if.control_hazard & bus_if.load_use_stall & rst_n;
   assign bus_if.busy           = ~idle;
   assign bus_if.state_dbg      = state_q;

`ifdef FLUSH_PERF_EN
   logic [31:0] perf_flush_q, perf_flush_d;
   logic [31:0] perf_pen_q, perf_pen_d;

   always_comb begin
      perf_flush_d = perf_flush_q;
      perf_pen_d   = perf_pen_q;
      if (take_hz)    perf_flush_d = perf_flush_q + 32'd1;
      if (flush_ifid) perf_pen_d   = perf_pen_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_flush_q <= 32'd0;
         perf_pen_q   <= 32'd0;
      end else begin
         perf_flush_q <= perf_flush_d;
         perf_pen_q   <= perf_pen_d;
      end
   end

   assign bus_if.perf_flush_cnt   = perf_flush_q;
   assign bus_if.perf_penalty_cnt = perf_pen_q;
`else
   assign bus_if.perf_flush_cnt   = 32'd0;
   assign bus_if.perf_penalty_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_ctrl_flush_redirect.sv
// Directed bench for ctrl_flush_redirect (DRAIN_CYCLES=1); perf expectations follow FLUSH_PERF_EN.
module tb_ctrl_flush_redirect;
   logic clk;
   logic rst_n;

   ctrl_flush_redirect_if #(.XLEN(32)) bus_if ();

   ctrl_flush_redirect #(.XLEN(32), .DRAIN_CYCLES(1)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_if (bus_if)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_q[$];

`ifdef FLUSH_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct {
      logic        ch;
      logic [31:0] tgt;
      logic        lus;
      logic        rdy;
      logic        rv;
      logic [31:0] pc;
      logic        fi;
      logic        fe;
      logic        pcs;
      logic        busy;
      logic [1:0]  st;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic ch, input logic [31:0] tgt, input logic lus, input logic rdy);
      bus_if.control_hazard = ch;
      bus_if.ex_target      = tgt;
      bus_if.load_use_stall = lus;
      bus_if.if_ready       = rdy;
   endtask

   task automatic chk_outs(input string tag, input logic rv, input logic [31:0] pc,
                           input logic fi, input logic fe, input logic pcs, input logic busy);
      chk({tag, ".redirect_valid"}, {31'd0, bus_if.redirect_valid}, {31'd0, rv});
      chk({tag, ".redirect_pc"},    bus_if.redirect_pc, pc);
      chk({tag, ".flush_ifid"},     {31'd0, bus_if.flush_ifid}, {31'd0, fi});
      chk({tag, ".flush_idex"},     {31'd0, bus_if.flush_idex}, {31'd0, fe});
      chk({tag, ".pc_stall"},       {31'd0, bus_if.pc_stall}, {31'd0, pcs});
      chk({tag, ".busy"},           {31'd0, bus_if.busy}, {31'd0, busy});
   endtask

   task automatic chk_perf(input string tag, input logic [31:0] flushes, input logic [31:0] pen);
      chk({tag, ".perf_flush_cnt"},   bus_if.perf_flush_cnt,   PERF ? flushes : 32'd0);
      chk({tag, ".perf_penalty_cnt"}, bus_if.perf_penalty_cnt, PERF ? pen : 32'd0);
   endtask

   initial begin
      // ch, tgt, lus, rdy | rv, pc, fi, fe, pcs, busy, st
      vecs[0]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      vecs[1]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
      vecs[2]  = '{1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[3]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1};
      vecs[4]  = '{1'b1, 32'h99, 1'b1, 1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2};
      vecs[5]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      vecs[6]  = '{1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[7]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1};
      vecs[8]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1};
      vecs[9]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1};
      vecs[10] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1};
      vecs[11] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h80, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2};
      vecs[12] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

      rst_n = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      #2;
      chk_outs("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_perf("reset", 32'd0, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #2;
         chk_outs($sformatf("idle%0d", i), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
         chk($sformatf("idle%0d.state", i), {30'd0, bus_if.state_dbg}, 32'd0);
      end
      chk_perf("idle", 32'd0, 32'd0);

      // table: single redirect, ignored inputs outside IDLE, held redirect with if_ready=0
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         drive(vecs[i].ch, vecs[i].tgt, vecs[i].lus, vecs[i].rdy);
         #2;
         chk_outs($sformatf("vec%0d", i), vecs[i].rv, vecs[i].pc, vecs[i].fi,
                  vecs[i].fe, vecs[i].pcs, vecs[i].busy);
         chk($sformatf("vec%0d.state", i), {30'd0, bus_if.state_dbg}, {30'd0, vecs[i].st});
      end
      chk_perf("table", 32'd2, 32'd9);

      // asynchronous reset while REDIRECT is pending
      @(negedge clk);
      drive(1'b1, 32'h100, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      #2;
      chk("rst_mid.pre_valid", {31'd0, bus_if.redirect_valid}, 32'd1);
      chk("rst_mid.pre_pc", bus_if.redirect_pc, 32'h100);
      #1 rst_n = 1'b0;
      #1;
      chk_outs("rst_mid", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_perf("rst_mid", 32'd0, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #2;
      chk_outs("post_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      // back-to-back redirects, scoreboard on redirect_pc
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive(1'b1, 32'(32'h10 * (k + 1)), 1'b0, 1'b1);
         exp_q.push_back(32'(32'h10 * (k + 1)));
         #2;
         chk($sformatf("b2b%0d.hz_fi", k), {31'd0, bus_if.flush_ifid}, 32'd1);
         chk($sformatf("b2b%0d.hz_fe", k), {31'd0, bus_if.flush_idex}, 32'd1);
         @(negedge clk);
         drive(1'b0, 32'h0, 1'b0, 1'b1);
         #2;
         chk($sformatf("b2b%0d.valid", k), {31'd0, bus_if.redirect_valid}, 32'd1);
         if (bus_if.redirect_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL b2b%0d.scoreboard: got 0x%08h expected none", k, bus_if.redirect_pc);
            end else begin
               chk($sformatf("b2b%0d.pc", k), bus_if.redirect_pc, exp_q.pop_front());
            end
         end
         @(negedge clk);
         #2;
         chk($sformatf("b2b%0d.drain_fi", k), {31'd0, bus_if.flush_ifid}, 32'd1);
         chk($sformatf("b2b%0d.drain_fe", k), {31'd0, bus_if.flush_idex}, 32'd0);
         chk($sformatf("b2b%0d.drain_rv", k), {31'd0, bus_if.redirect_valid}, 32'd0);
      end
      @(negedge clk);
      #2;
      chk_outs("b2b_end", 1'b0, 32'h30, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_perf("b2b_end", 32'd3, 32'd9);
      chk("b2b.exp_q_empty", 32'(exp_q.size()), 32'd0);

      // final report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
